// File: rtl/mc_cpu_core.sv
// mc_cpu_core: multicycle memory-to-memory CPU with an integrated single-master
// bus engine. Each instruction is a command word followed by up to three
// operand-address words (dest, srcA, srcB). The core loads the sources,
// computes, optionally stores the result, then advances the PC.
module mc_cpu_core #(
  parameter int DW       = 32,
  parameter int AW       = 16,
  parameter int RESET_PC = 0,
  parameter int TIMEOUT  = 255
) (
  input  logic          clk,
  input  logic          W_RST,
  input  logic [DW-1:0] W_DATA_I,
  input  logic          W_ACK,
  output logic [DW-1:0] W_DATA_O,
  output logic [AW-1:0] W_ADDR,
  output logic          W_WRITE,
  output logic          W_STB,
  output logic          halted,
  output logic          bus_err,
  output logic          retire,
  output logic [AW-1:0] pc
);

  // state    | meaning
  // S_FETCH  | read command word at pc
  // S_DECODE | compute length; retire a pending skip without operand access
  // S_OPW    | read each present operand word, pc+1 onward
  // S_LOAD_A | A = mem[srcA] when present, else 0
  // S_LOAD_B | B = mem[srcB] when present, else 0
  // S_EXEC   | compute C, update skip flag
  // S_STORE  | write C to dest when requested
  // S_NEXT   | advance pc (or jump), pulse retire
  // S_HALT   | stopped by HALT opcode or bus timeout; left only by reset
  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_OPW, S_LOAD_A, S_LOAD_B, S_EXEC, S_STORE, S_NEXT, S_HALT
  } state_t;

  localparam logic [3:0] OP_MOV = 4'd1, OP_ADD = 4'd2, OP_SUB = 4'd3, OP_AND = 4'd4;
  localparam logic [3:0] OP_OR  = 4'd5, OP_XOR = 4'd6, OP_SKZ = 4'd7, OP_JMP = 4'd8;
  localparam logic [3:0] OP_SHL = 4'd9, OP_SHR = 4'd10, OP_HALT = 4'd15;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  state_t        state_q, state_n;
  logic [3:0]    op_q, op_n, flg_q, flg_n;
  logic [2:0]    need_q, need_n;
  logic [AW-1:0] opw_addr_q, opw_addr_n, dest_q, dest_n, srca_q, srca_n, srcb_q, srcb_n;
  logic [DW-1:0] a_q, a_n, b_q, b_n, c_q, c_n;
  logic [TW-1:0] tmo_q, tmo_n;
  logic          skip_q, skip_n;
  logic [AW-1:0] pc_n, addr_n;
  logic [DW-1:0] wdata_n;
  logic          stb_n, write_n, halted_n, bus_err_n, retire_n;

  logic          f1, f2, f3, fs, do_store, req, req_wr, xfer_done;
  logic [2:0]    len;
  logic [AW-1:0] req_addr;

  assign f1       = flg_q[3];
  assign f2       = flg_q[2];
  assign f3       = flg_q[1];
  assign fs       = flg_q[0];
  assign len      = 3'd1 + {2'b0, f1} + {2'b0, f2} + {2'b0, f3};
  assign do_store = fs & f1 & (op_q != OP_SKZ) & (op_q != OP_JMP) & (op_q != OP_HALT);

  // Next-state, datapath and bus-engine logic
  always_comb begin
    state_n    = state_q;
    op_n       = op_q;
    flg_n      = flg_q;
    need_n     = need_q;
    opw_addr_n = opw_addr_q;
    dest_n     = dest_q;
    srca_n     = srca_q;
    srcb_n     = srcb_q;
    a_n        = a_q;
    b_n        = b_q;
    c_n        = c_q;
    tmo_n      = tmo_q;
    skip_n     = skip_q;
    pc_n       = pc;
    addr_n     = W_ADDR;
    wdata_n    = W_DATA_O;
    stb_n      = W_STB;
    write_n    = W_WRITE;
    halted_n   = halted;
    bus_err_n  = bus_err;
    retire_n   = 1'b0;
    req        = 1'b0;
    req_wr     = 1'b0;
    req_addr   = '0;

    case (state_q)
      S_FETCH:  begin req = 1'b1; req_addr = pc; end
      S_OPW:    begin req = 1'b1; req_addr = opw_addr_q; end
      S_LOAD_A: begin req = f2; req_addr = srca_q; end
      S_LOAD_B: begin req = f3; req_addr = srcb_q; end
      S_STORE:  begin req = do_store; req_wr = 1'b1; req_addr = dest_q; end
      default:  ;
    endcase
    xfer_done = req & W_STB & W_ACK;

    case (state_q)
      S_FETCH: if (xfer_done) begin
        op_n    = W_DATA_I[DW-1:DW-4];
        flg_n   = W_DATA_I[DW-5:DW-8];
        state_n = S_DECODE;
      end
      S_DECODE: begin
        if (skip_q) begin
          skip_n   = 1'b0;
          pc_n     = pc + AW'(len);
          retire_n = 1'b1;
          state_n  = S_FETCH;
        end else begin
          need_n     = {f1, f2, f3};
          opw_addr_n = pc + AW'(1);
          dest_n     = '0;
          srca_n     = '0;
          srcb_n     = '0;
          state_n    = (f1 | f2 | f3) ? S_OPW : S_LOAD_A;
        end
      end
      S_OPW: if (xfer_done) begin
        if (need_q[2]) begin
          dest_n = W_DATA_I[AW-1:0];
          need_n = {1'b0, need_q[1:0]};
        end else if (need_q[1]) begin
          srca_n = W_DATA_I[AW-1:0];
          need_n = {2'b0, need_q[0]};
        end else begin
          srcb_n = W_DATA_I[AW-1:0];
          need_n = '0;
        end
        opw_addr_n = opw_addr_q + AW'(1);
        if (need_n == '0) state_n = S_LOAD_A;
      end
      S_LOAD_A: begin
        if (!f2) begin
          a_n = '0;
          state_n = S_LOAD_B;
        end else if (xfer_done) begin
          a_n = W_DATA_I;
          state_n = S_LOAD_B;
        end
      end
      S_LOAD_B: begin
        if (!f3) begin
          b_n = '0;
          state_n = S_EXEC;
        end else if (xfer_done) begin
          b_n = W_DATA_I;
          state_n = S_EXEC;
        end
      end
      S_EXEC: begin
        c_n = '0;
        case (op_q)
          OP_MOV:  c_n = a_q;
          OP_ADD:  c_n = a_q + b_q;
          OP_SUB:  c_n = a_q - b_q;
          OP_AND:  c_n = a_q & b_q;
          OP_OR:   c_n = a_q | b_q;
          OP_XOR:  c_n = a_q ^ b_q;
          OP_SKZ:  skip_n = (a_q == '0);
          OP_SHL:  c_n = a_q << b_q[4:0];
          OP_SHR:  c_n = a_q >> b_q[4:0];
          default: ;
        endcase
        state_n = S_STORE;
      end
      S_STORE: if (!do_store || xfer_done) state_n = S_NEXT;
      S_NEXT: begin
        retire_n = 1'b1;
        if (op_q == OP_HALT) begin
          halted_n = 1'b1;
          state_n  = S_HALT;
        end else begin
          pc_n    = (op_q == OP_JMP && f1) ? dest_q : pc + AW'(len);
          state_n = S_FETCH;
        end
      end
      default: ;
    endcase

    // Bus engine: launch from idle, finish on ACK, or abort when the
    // down-counter reaches its terminal count. Placed last so a timeout
    // overrides any state transition above.
    if (req) begin
      if (!W_STB) begin
        stb_n   = 1'b1;
        addr_n  = req_addr;
        write_n = req_wr;
        wdata_n = c_q;
        tmo_n   = TW'(TIMEOUT);
      end else if (W_ACK) begin
        stb_n   = 1'b0;
        write_n = 1'b0;
      end else if (TIMEOUT != 0) begin
        if (tmo_q == TW'(1)) begin
          stb_n     = 1'b0;
          write_n   = 1'b0;
          bus_err_n = 1'b1;
          halted_n  = 1'b1;
          state_n   = S_HALT;
        end else begin
          tmo_n = tmo_q - TW'(1);
        end
      end
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (W_RST) begin
      state_q    <= S_FETCH;
      pc         <= AW'(RESET_PC);
      W_STB      <= 1'b0;
      W_WRITE    <= 1'b0;
      W_ADDR     <= '0;
      W_DATA_O   <= '0;
      halted     <= 1'b0;
      bus_err    <= 1'b0;
      retire     <= 1'b0;
      skip_q     <= 1'b0;
      op_q       <= '0;
      flg_q      <= '0;
      need_q     <= '0;
      opw_addr_q <= '0;
      dest_q     <= '0;
      srca_q     <= '0;
      srcb_q     <= '0;
      a_q        <= '0;
      b_q        <= '0;
      c_q        <= '0;
      tmo_q      <= '0;
    end else begin
      state_q    <= state_n;
      pc         <= pc_n;
      W_STB      <= stb_n;
      W_WRITE    <= write_n;
      W_ADDR     <= addr_n;
      W_DATA_O   <= wdata_n;
      halted     <= halted_n;
      bus_err    <= bus_err_n;
      retire     <= retire_n;
      skip_q     <= skip_n;
      op_q       <= op_n;
      flg_q      <= flg_n;
      need_q     <= need_n;
      opw_addr_q <= opw_addr_n;
      dest_q     <= dest_n;
      srca_q     <= srca_n;
      srcb_q     <= srcb_n;
      a_q        <= a_n;
      b_q        <= b_n;
      c_q        <= c_n;
      tmo_q      <= tmo_n;
    end
  end

endmodule

// File: tb/tb_mc_cpu_core.sv
// Bench for mc_cpu_core: a memory slave with configurable wait states, an
// instruction-level reference interpreter, and directed plus random programs.
module tb_mc_cpu_core;

  logic        clk = 1'b0;
  logic        W_RST = 1'b1;
  logic [31:0] W_DATA_I = '0;
  logic        W_ACK = 1'b0;
  logic [31:0] W_DATA_O;
  logic [15:0] W_ADDR;
  logic        W_WRITE, W_STB, halted, bus_err, retire;
  logic [15:0] pc;

  mc_cpu_core #(.DW(32), .AW(16), .RESET_PC(0), .TIMEOUT(8)) dut (
    .clk(clk), .W_RST(W_RST), .W_DATA_I(W_DATA_I), .W_ACK(W_ACK),
    .W_DATA_O(W_DATA_O), .W_ADDR(W_ADDR), .W_WRITE(W_WRITE), .W_STB(W_STB),
    .halted(halted), .bus_err(bus_err), .retire(retire), .pc(pc)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        wr;
    logic [15:0] addr;
    logic [31:0] data;
  } xfer_t;

  localparam logic [31:0] HALT_W = 32'hF000_0000;

  logic [31:0] mem [0:65535];
  logic [31:0] mm  [0:65535];
  xfer_t obs_q[$];
  xfer_t exp_q[$];
  int    n_cmp = 0, n_err = 0;
  int    ret_cnt = 0, stb_hi = 0, exp_ret = 0;
  logic [15:0] exp_pc;
  bit    noack = 0, rand_wait = 0;
  int    fixed_wait = 0;
  bit    in_xfer = 0, stable = 0;
  int    wcnt = 0, cur_wait = 0;
  xfer_t cap;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Memory slave and bus monitor, evaluated away from the active edge
  always @(negedge clk) begin
    if (W_RST) begin
      W_ACK   = 1'b0;
      in_xfer = 0;
    end else begin
      if (retire) ret_cnt++;
      if (W_STB) stb_hi++;
      if (W_ACK) begin
        chk("stable", 64'(stable), 64'd1);
        obs_q.push_back(cap);
        W_ACK    = 1'b0;
        W_DATA_I = $urandom;
        in_xfer  = 0;
        chk("stb_gap", 64'(W_STB), 64'd0);
      end else if (W_STB) begin
        if (!in_xfer) begin
          in_xfer  = 1;
          stable   = 1;
          wcnt     = 0;
          cap      = {W_WRITE, W_ADDR, W_WRITE ? W_DATA_O : mem[W_ADDR]};
          cur_wait = rand_wait ? int'($urandom_range(0, 3)) : fixed_wait;
        end else if (W_ADDR !== cap.addr || W_WRITE !== cap.wr ||
                     (W_WRITE && W_DATA_O !== cap.data)) begin
          stable = 0;
        end
        if (!noack) begin
          if (wcnt == cur_wait) begin
            W_ACK    = 1'b1;
            W_DATA_I = mem[W_ADDR];
            if (W_WRITE) mem[W_ADDR] = W_DATA_O;
          end else begin
            wcnt++;
          end
        end
      end
    end
  end

  // Instruction-level interpreter: produces the expected bus transaction list
  task automatic model_run();
    logic [15:0] p, ptr, dst, sa, sb, len;
    logic [31:0] w, v, a, b, c;
    logic [3:0]  op;
    logic        f1, f2, f3, fs;
    bit          sk;
    sk = 0;
    p  = 16'd0;
    exp_q.delete();
    exp_ret = 0;
    exp_pc  = 16'hFFFF;
    for (int step = 0; step < 2000; step++) begin
      w = mm[p];
      exp_q.push_back({1'b0, p, w});
      {op, f1, f2, f3, fs} = w[31:24];
      len = 16'(32'd1 + f1 + f2 + f3);
      exp_ret++;
      if (sk) begin
        sk = 0;
        p  = p + len;
        continue;
      end
      ptr = p + 16'd1;
      dst = 0; sa = 0; sb = 0; a = 0; b = 0; c = 0;
      if (f1) begin v = mm[ptr]; dst = v[15:0]; exp_q.push_back({1'b0, ptr, v}); ptr++; end
      if (f2) begin v = mm[ptr]; sa  = v[15:0]; exp_q.push_back({1'b0, ptr, v}); ptr++; end
      if (f3) begin v = mm[ptr]; sb  = v[15:0]; exp_q.push_back({1'b0, ptr, v}); ptr++; end
      if (f2) begin a = mm[sa]; exp_q.push_back({1'b0, sa, a}); end
      if (f3) begin b = mm[sb]; exp_q.push_back({1'b0, sb, b}); end
      case (op)
        4'd1:  c = a;
        4'd2:  c = a + b;
        4'd3:  c = a - b;
        4'd4:  c = a & b;
        4'd5:  c = a | b;
        4'd6:  c = a ^ b;
        4'd7:  sk = (a == 0);
        4'd9:  c = a << b[4:0];
        4'd10: c = a >> b[4:0];
        default: ;
      endcase
      if (fs && f1 && !(op inside {4'd7, 4'd8, 4'd15})) begin
        mm[dst] = c;
        exp_q.push_back({1'b1, dst, c});
      end
      if (op == 4'd15) begin
        exp_pc = p;
        return;
      end
      if (op == 4'd8 && f1) p = dst;
      else p = p + len;
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 65536; i++) mem[i] = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    W_RST = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    obs_q.delete();
    ret_cnt = 0;
    stb_hi  = 0;
    W_RST   = 1'b0;
  endtask

  task automatic run_and_check(input string tag, input int budget);
    int cyc, idle_ref, n;
    mm = mem;
    model_run();
    do_reset();
    for (cyc = 0; cyc < budget && !halted; cyc++) @(negedge clk);
    chk({tag, "_halted"}, 64'(halted), 64'd1);
    idle_ref = stb_hi;
    repeat (20) @(negedge clk);
    chk({tag, "_idle"}, 64'(stb_hi), 64'(idle_ref));
    chk({tag, "_ntx"}, 64'(obs_q.size()), 64'(exp_q.size()));
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk($sformatf("%s_tx%0d", tag, i), 64'(obs_q[i]), 64'(exp_q[i]));
    chk({tag, "_retire"}, 64'(ret_cnt), 64'(exp_ret));
    chk({tag, "_pc"}, 64'(pc), 64'(exp_pc));
    chk({tag, "_buserr"}, 64'(bus_err), 64'd0);
  endtask

  function automatic int count_writes();
    int k = 0;
    foreach (obs_q[i]) if (obs_q[i].wr) k++;
    return k;
  endfunction

  task automatic gen_prog();
    int p;
    logic [3:0] op, f;
    clear_mem();
    for (int i = 0; i < 64; i++)
      mem[16'h1000 + i] = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
    p = 0;
    for (int k = 0; k < 16; k++) begin
      op = 4'($urandom_range(0, 14));
      f  = 4'($urandom_range(0, 15));
      if (op == 4'd8) f[3] = 1'b0;
      if (op == 4'd0 || op > 4'd10) f[0] = 1'b0;
      mem[p] = {op, f, 24'($urandom)};
      p++;
      for (int j = 3; j >= 1; j--)
        if (f[j]) begin
          mem[p] = 32'h1000 + $urandom_range(0, 63);
          p++;
        end
    end
    mem[p]     = HALT_W;
    mem[p + 1] = HALT_W;
  endtask

  initial begin
    int cyc;
    clear_mem();

    // Reset state while W_RST is held
    W_RST = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_stb", 64'(W_STB), 64'd0);
    chk("rst_write", 64'(W_WRITE), 64'd0);
    chk("rst_addr", 64'(W_ADDR), 64'd0);
    chk("rst_wdata", 64'(W_DATA_O), 64'd0);
    chk("rst_halted", 64'(halted), 64'd0);
    chk("rst_buserr", 64'(bus_err), 64'd0);
    chk("rst_retire", 64'(retire), 64'd0);
    chk("rst_pc", 64'(pc), 64'd0);

    // NOP then HALT, zero-wait
    clear_mem();
    mem[1] = HALT_W;
    fixed_wait = 0;
    run_and_check("nop", 500);
    chk("nop_pc_const", 64'(pc), 64'd1);
    chk("nop_ret_const", 64'(ret_cnt), 64'd2);

    // JMP to 0x10, 4-word ADD, HALT; zero and three wait states
    for (int ws = 0; ws <= 3; ws += 3) begin
      clear_mem();
      mem[0] = 32'h8800_0000; mem[1] = 32'h10;
      mem[16'h10] = 32'h2F00_0000;
      mem[16'h11] = 32'h40; mem[16'h12] = 32'h41; mem[16'h13] = 32'h42;
      mem[16'h14] = HALT_W;
      mem[16'h41] = 32'd7; mem[16'h42] = 32'hFFFF_FFFE;
      fixed_wait = ws;
      run_and_check($sformatf("add_w%0d", ws), 1000);
      chk("add_result", 64'(mem[16'h40]), 64'd5);
      chk("add_nwrites", 64'(count_writes()), 64'd1);
      chk("add_pc_const", 64'(pc), 64'h14);
    end
    fixed_wait = 0;

    // SKZ with zero source skips the following 4-word ADD
    clear_mem();
    mem[0] = 32'h7400_0000; mem[1] = 32'h50;
    mem[2] = 32'h2F00_0000; mem[3] = 32'h40; mem[4] = 32'h41; mem[5] = 32'h42;
    mem[6] = HALT_W;
    mem[16'h41] = 32'd3; mem[16'h42] = 32'd4;
    run_and_check("skz", 1000);
    chk("skz_nwrites", 64'(count_writes()), 64'd0);
    chk("skz_pc_const", 64'(pc), 64'd6);
    chk("skz_ret_const", 64'(ret_cnt), 64'd3);

    // JMP to 0x0200, HALT there, bus stays quiet
    clear_mem();
    mem[0] = 32'h8800_0000; mem[1] = 32'h0200;
    mem[16'h0200] = HALT_W;
    run_and_check("jmp", 1000);
    chk("jmp_pc_const", 64'(pc), 64'h200);
    cyc = stb_hi;
    repeat (100) @(negedge clk);
    chk("jmp_quiet", 64'(stb_hi), 64'(cyc));
    chk("jmp_still_halted", 64'(halted), 64'd1);

    // Random programs with random wait states
    rand_wait = 1;
    for (int t = 0; t < 6; t++) begin
      gen_prog();
      run_and_check($sformatf("rnd%0d", t), 4000);
    end
    rand_wait = 0;

    // Timeout: slave never acknowledges
    clear_mem();
    noack = 1;
    do_reset();
    for (cyc = 0; cyc < 60 && !halted; cyc++) @(negedge clk);
    chk("to_halted", 64'(halted), 64'd1);
    chk("to_buserr", 64'(bus_err), 64'd1);
    chk("to_stb_cycles", 64'(stb_hi), 64'd8);
    chk("to_stb_low", 64'(W_STB), 64'd0);
    W_RST = 1'b1;
    @(negedge clk);
    chk("to_rst_pc", 64'(pc), 64'd0);
    chk("to_rst_halted", 64'(halted), 64'd0);
    chk("to_rst_buserr", 64'(bus_err), 64'd0);

    // Reset while a transfer is outstanding drops W_STB next cycle
    W_RST = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_stb_high", 64'(W_STB), 64'd1);
    W_RST = 1'b1;
    @(negedge clk);
    chk("mid_stb_dropped", 64'(W_STB), 64'd0);
    noack = 0;
    W_RST = 1'b0;
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
